// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared frame-buffer constants and arbiter state encoding
//
// Purpose: shared by the frame-buffer arbiter, the VGA timing generator and
//          the pattern writer so that all agree on pixel/address geometry.
// Contents:
//   DATA_W_DEF   - pixel width (RGB444)
//   ADDR_W_DEF   - frame-buffer address width
//   FB_WORDS_DEF - pixels per frame (320x240)
//   fb_state_e   - arbiter sequencing states
package vga_pkg;

  localparam int DATA_W_DEF   = 12;
  localparam int ADDR_W_DEF   = 17;
  localparam int FB_WORDS_DEF = 76800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FILL  = 2'd2,
    ST_RUN   = 2'd3
  } fb_state_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - writer, display-fetch and RAM bus bundle
//
// Purpose: groups the three buses the frame-buffer arbiter sits between.
// Signals (suffixes are from the arbiter's point of view):
//   wr_valid_i/wr_ready_o/wr_addr_i/wr_data_i   - pixel writer handshake
//   rd_req_i/rd_addr_i/rd_data_o/rd_valid_o     - display pixel fetch
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o    - single-port RAM request
//   mem_rdata_i                                 - RAM read data (1-cycle latency)
// Modports: slave = arbiter, master = surrounding writer/display/RAM.
interface vga_fb_arbiter_if
  import vga_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;

  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i,
    input  rd_req_i, rd_addr_i,
    input  mem_rdata_i,
    output wr_ready_o, rd_data_o, rd_valid_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i,
    output rd_req_i, rd_addr_i,
    output mem_rdata_i,
    input  wr_ready_o, rd_data_o, rd_valid_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer sequencer and single-port RAM arbiter
//
// Purpose: fills the frame buffer from the pixel writer with the display off,
//          then enables VGA timing and shares the RAM, display reads first.
// Ports:
//   clk_i, rstn_i  - clock, asynchronous active-low reset
//   en_i           - sequence enable; low returns to IDLE on the next edge
//   vga_en_o       - enable to the VGA timing generator (high in RUN)
//   write_done_o   - fill complete level (high in RUN)
//   bus            - writer / display fetch / RAM bundle (slave modport)
// Optional feature: define VGA_FB_CLEAR_EN to sweep CLEAR_COLOR over the
//   whole buffer before the writer fill starts.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int          DATA_W      = DATA_W_DEF,
  parameter int          ADDR_W      = ADDR_W_DEF,
  parameter int          FB_WORDS    = FB_WORDS_DEF,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  output logic             vga_en_o,
  output logic             write_done_o,
  vga_fb_arbiter_if.slave  bus
);

  // One extra bit so the counter can hold FB_WORDS itself after the fill.
  typedef logic [ADDR_W:0] cnt_t;
  localparam cnt_t LAST_IDX = cnt_t'(FB_WORDS - 1);
  localparam logic [DATA_W-1:0] CLEAR_PIX = DATA_W'(CLEAR_COLOR);

  fb_state_e state_q, state_d;
  cnt_t      cnt_q, cnt_d;
  logic      rd_valid_q, rd_valid_d;

  logic              wr_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    wr_ready   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en_i) begin
`ifdef VGA_FB_CLEAR_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_FILL;
`endif
        end
      end

      // The counter doubles as the sweep address while clearing.
      ST_CLEAR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cnt_q[ADDR_W-1:0];
        mem_wdata = CLEAR_PIX;
`ifdef VGA_FB_CLEAR_EN
        if (cnt_q == LAST_IDX) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_FILL: begin
        wr_ready = 1'b1;
        if (bus.wr_valid_i) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = bus.wr_addr_i;
          mem_wdata = bus.wr_data_i;
          cnt_d     = cnt_q + cnt_t'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = ST_RUN;
          end
        end
      end

      // Display reads pre-empt the writer combinationally; the writer holds
      // its beat until a cycle with no fetch.
      ST_RUN: begin
        rd_valid_d = bus.rd_req_i;
        if (bus.rd_req_i) begin
          mem_en   = 1'b1;
          mem_addr = bus.rd_addr_i;
        end else begin
          wr_ready = 1'b1;
          if (bus.wr_valid_i) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = bus.wr_addr_i;
            mem_wdata = bus.wr_data_i;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign bus.wr_ready_o  = wr_ready;
  assign bus.mem_en_o    = mem_en;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.rd_data_o   = rd_valid_q ? bus.mem_rdata_i : '0;

  assign write_done_o = (state_q == ST_RUN);
  assign vga_en_o     = (state_q == ST_RUN);

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Sequences the VGA frame buffer and shares its single-port RAM between two requesters: a pixel writer (pattern/host side) and the VGA pixel fetch (display side).
- Runs an initial fill phase with the display disabled and raises write_done_o when the fill completes.
- Then enables VGA timing; during display, reads have absolute priority and writes go only into free cycles.
- Sits in top between the writer, the VGA timing generator and the frame-buffer BRAM.

Parameters:
- DATA_W, 12, pixel width (RGB444).
- ADDR_W, 17, frame-buffer address width.
- FB_WORDS, 76800, pixels per frame (320x240); fill completes after this many accepted writes.
- CLEAR_COLOR, 12'h000, pixel value used by the optional clear sweep.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- en_i  in  1  sequence enable; low forces IDLE.
- wr_valid_i  in  1  writer beat valid.
- wr_ready_o  out  1  writer beat accepted when valid&ready.
- wr_addr_i  in  ADDR_W  writer pixel address.
- wr_data_i  in  DATA_W  writer pixel data.
- rd_req_i  in  1  display fetch request (one per pixel clock enable).
- rd_addr_i  in  ADDR_W  display fetch address.
- rd_data_o  out  DATA_W  fetched pixel.
- rd_valid_o  out  1  rd_data_o valid.
- vga_en_o  out  1  enable to VGA timing generator.
- write_done_o  out  1  fill complete (level).
- mem_en_o  out  1  RAM enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  ADDR_W  RAM address.
- mem_wdata_o  out  DATA_W  RAM write data.
- mem_rdata_i  in  DATA_W  RAM read data, 1-cycle registered latency.

Behaviour:
- Reset (async, rstn_i low):
  - State IDLE; fill counter 0.
  - All outputs 0: wr_ready_o, rd_valid_o, vga_en_o, write_done_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o.
- FSM transitions:
  - IDLE -> FILL when en_i=1 (CLEAR first when the optional feature is present).
  - FILL -> RUN after the FB_WORDS-th accepted write.
  - Any state -> IDLE when en_i=0, taken on the next edge; counter cleared, write_done_o and vga_en_o drop.
  - Reset mid-operation aborts immediately with no partial state retained.
- IDLE: wr_ready_o=0; rd_req_i ignored.
- FILL:
  - wr_ready_o=1; rd_req_i ignored; vga_en_o=0.
  - Each accepted beat drives mem_en_o=mem_we_o=1 with wr_addr_i/wr_data_i in the same cycle (combinational pass-through).
  - Counter, width ADDR_W+1, increments per accepted beat.
  - The FB_WORDS-th accept moves to RUN and sets write_done_o and vga_en_o from the following cycle.
- RUN:
  - write_done_o=1, vga_en_o=1.
  - Read priority: when rd_req_i=1, mem_en_o=1, mem_we_o=0, mem_addr_o=rd_addr_i, and wr_ready_o=0 in that same cycle (combinational from rd_req_i).
  - rd_valid_o is rd_req_i delayed one cycle; rd_data_o=mem_rdata_i.
  - When rd_req_i=0, a writer beat with wr_valid_i=1 is accepted and written.
  - Writes in RUN do not change the counter.
- Simultaneous rd_req_i and wr_valid_i in RUN: read wins; the write stalls with data held by the writer.
- Writer address is not range-checked; the writer guarantees addresses < FB_WORDS.

Optional Feature:
- VGA_FB_CLEAR_EN defined:
  - Adds a CLEAR state between IDLE and FILL.
  - Writes CLEAR_COLOR to addresses 0..FB_WORDS-1, one per cycle, with wr_ready_o=0.
  - Moves to FILL the cycle after address FB_WORDS-1 is written.
  - en_i=0 aborts to IDLE.
- Not defined: IDLE goes directly to FILL.

Decomposition:
- Shared package vga_pkg holds:
  - FSM state typedef/localparams (IDLE, CLEAR, FILL, RUN).
  - Default DATA_W/ADDR_W/FB_WORDS constants, also shared with the VGA timing generator and pattern writer.
- No sub-module; the FSM and mux are small enough to stay flat.

Test Plan (FB_WORDS=16, ADDR_W=5):
- en_i=1, wr_valid_i held high with addr k/data k for 16 beats:
  - exactly 16 RAM writes occur;
  - write_done_o and vga_en_o rise the cycle after the 16th accept.
- In RUN, rd_req_i=1 with rd_addr_i=5 together with wr_valid_i=1:
  - wr_ready_o=0 and mem_we_o=0;
  - next cycle rd_valid_o=1 and rd_data_o=5;
  - the write is accepted the first cycle rd_req_i=0.
- en_i dropped after 7 fill beats:
  - IDLE next cycle, counter 0, write_done_o=0;
  - re-enable requires 16 fresh beats.
- rstn_i pulsed low in RUN:
  - all outputs 0 asynchronously, before the next clock edge.
- With VGA_FB_CLEAR_EN:
  - 16 writes of 12'h000 precede the first wr_ready_o=1;
  - write_done_o rises only after 16 further writer beats.
- Writer stalls (wr_valid_i toggling 1/0) during FILL:
  - counter advances only on valid&ready;
  - write_done_o still rises after exactly 16 accepts.
